// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pop controller between an async FIFO and a
// valid/ready consumer. Each pop runs IDLE -> POP -> WAIT so the stale
// rempty flag seen right after a pointer advance is never acted on.
// Optional build macro FIFO_RD_CTRL_CNT_EN adds a saturating rd_count
// output that counts consumer handshakes.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  enable,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef FIFO_RD_CTRL_CNT_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic                    rinc_reg, rinc_next;
  logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
  logic                    out_valid_reg, out_valid_next;
  logic                    handshake;
  logic                    fetch;

  // Consumer takes the current word; a fetch may be issued only from IDLE
  // and only when the output register is free or being emptied this cycle.
  always_comb begin
    handshake = out_valid_reg & out_ready;
    fetch     = (state_reg == IDLE) & enable & ~rempty &
                (~out_valid_reg | out_ready);
  end

  // Next-state and next-output logic; a fetch overrides the handshake clear
  // so a same-cycle accept and reload keeps out_valid high without a bubble.
  always_comb begin
    state_next     = state_reg;
    rinc_next      = 1'b0;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    if (handshake) begin
      out_valid_next = 1'b0;
    end
    case (state_reg)
      IDLE: begin
        if (fetch) begin
          state_next     = POP;
          rinc_next      = 1'b1;
          out_data_next  = rdata;
          out_valid_next = 1'b1;
        end
      end
      POP: begin
        // rinc is high for exactly this cycle; enable no longer matters.
        state_next = WAIT;
      end
      WAIT: begin
        // rempty still reflects the old pointer here, so it is ignored.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately so a
  // pop interrupted in POP is never seen as issued.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg     <= IDLE;
      rinc_reg      <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rinc_reg      <= rinc_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign rinc      = rinc_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);

`ifdef FIFO_RD_CTRL_CNT_EN
  logic [15:0] rd_count_reg;

  // Count accepted words, sticking at the maximum instead of wrapping.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_count_reg <= 16'd0;
    end else if (handshake && (rd_count_reg != 16'hFFFF)) begin
      rd_count_reg <= rd_count_reg + 16'd1;
    end
  end

  assign rd_count = rd_count_reg;
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the FIFO read word and the output word.
REQ-002 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 rrst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  fetch permission; when low, no new FIFO pop is started.
REQ-005 rempty  input  1  registered FIFO-empty flag from the FIFO read side.
REQ-006 rdata  input  DATA_WIDTH  FIFO read word at the current read address, valid in the same cycle.
REQ-007 rinc  output  1  FIFO read-increment pulse, driven directly from a flop.
REQ-008 out_data  output  DATA_WIDTH  word presented to the consumer, driven directly from a flop.
REQ-009 out_valid  output  1  out_data holds an unconsumed word.
REQ-010 out_ready  input  1  consumer accepts out_data in any cycle where out_valid and out_ready are both high.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The controller SHALL use a three-state FSM: IDLE, POP, WAIT.
REQ-013 In IDLE, fetch condition = enable & !rempty & (!out_valid | out_ready).
REQ-014 In IDLE, when the fetch condition holds, the next edge SHALL load out_data<=rdata, set out_valid<=1, set rinc<=1, and move to POP.
REQ-015 In POP, rinc SHALL be high for exactly this one cycle; the next edge SHALL clear rinc and move to WAIT.
REQ-016 In WAIT, rinc SHALL be low and rempty SHALL be ignored, because it is stale for one cycle after the pointer advance; the next edge SHALL return to IDLE.
REQ-017 Minimum spacing between rinc pulses is 3 cycles; rinc SHALL never be high in two consecutive cycles.
REQ-018 A consumer handshake (out_valid & out_ready) without a simultaneous fetch SHALL clear out_valid at the next edge.
REQ-019 A handshake and a fetch in the same IDLE cycle SHALL load the new word and keep out_valid high, with no bubble and no lost word.
REQ-020 out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-021 Deasserting enable in POP or WAIT SHALL NOT abort the sequence; the controller SHALL complete it and then stay in IDLE.
REQ-022 rempty=1 in IDLE SHALL hold the FSM in IDLE with rinc=0, whatever the values of enable and out_ready.
REQ-023 Latency: a non-empty FIFO with out_valid=0 and enable=1 SHALL give out_valid=1 one cycle after the IDLE decision cycle.
REQ-024 busy SHALL equal (state != IDLE).

Reset
REQ-025 Asserting rrst_n low SHALL immediately force state=IDLE, rinc=0, out_valid=0, out_data=0, busy=0, independent of rclk.
REQ-026 A reset during POP SHALL drop rinc at once; a pop that has not completed SHALL be treated as not issued.
REQ-027 After reset release, the first pop SHALL NOT start before the first rising edge at which rrst_n is high.

Configuration
REQ-028 Macro FIFO_RD_CTRL_CNT_EN defined: the module SHALL add output rd_count [15:0], reset to 0, incremented on each consumer handshake and saturating at 16'hFFFF.
REQ-029 Macro FIFO_RD_CTRL_CNT_EN undefined: the module SHALL have no rd_count port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-030 Single word: rempty=0, rdata=8'hA5, enable=1, out_ready=0 -> out_valid=1 and out_data=A5 after one edge; rinc high for exactly one cycle; state back to IDLE after 3 cycles.
REQ-031 Back-to-back streaming: FIFO holds 4 words, out_ready=1 throughout -> rinc pulses exactly 3 cycles apart; 4 handshakes in order; no duplicated or skipped word.
REQ-032 Backpressure: out_ready=0 with 2 words queued -> exactly one rinc; out_data stable; second pop starts in the IDLE cycle where out_ready rises.
REQ-033 Stale-empty boundary: last word popped while rempty is still 0 in WAIT -> no second rinc; FSM idles once rempty=1.
REQ-034 enable dropped during POP -> sequence completes; no further rinc while enable=0; resumes once enable=1.
REQ-035 rrst_n pulsed low during POP -> rinc, out_valid and busy fall asynchronously; with FIFO_RD_CTRL_CNT_EN defined, rd_count returns to 0.
